// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: ID-stage direction prediction from a table of 2-bit counters,
// ALU-stage misprediction detection with flush/redirect, and saturating performance counters.
module branch_predictor_unit #(
  parameter int         IDX_BITS   = 3,
  parameter int         HIST_BITS  = 3,
  parameter int         MODE       = 1,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         ID_pc,
  input  logic                ID_stage_branch,
  output logic                signal_to_take_branch,
  output logic [IDX_BITS-1:0] ID_pred_index,
  input  logic                ALU_stage_branch,
  input  logic                ALU_stage_branch_result,
  input  logic                ALU_predicted_taken,
  input  logic [IDX_BITS-1:0] ALU_pred_index,
  input  logic [31:0]         ALU_pc_plus4,
  input  logic [31:0]         ALU_branch_target,
  output logic                flush,
  output logic [31:0]         redirect_pc,
  output logic [CNT_BITS-1:0] branch_count,
  output logic [CNT_BITS-1:0] mispredict_count
);
  localparam int DEPTH = 32'd1 << IDX_BITS;

  logic [1:0]          table_r [DEPTH];
  logic [HIST_BITS-1:0] ghr_r;
  logic [HIST_BITS:0]   ghr_shift_s;
  logic [IDX_BITS-1:0]  ghr_ext_s;
  logic [IDX_BITS-1:0]  pc_index_s;
  logic [CNT_BITS-1:0]  branch_count_r;
  logic [CNT_BITS-1:0]  mispredict_count_r;
  logic                 mispredict_s;
  logic                 unused_pc_bits_s;

  // Encoding 00/01 predict taken; taken moves toward 00, not-taken toward 11, both saturate.
  function automatic logic [1:0] counter_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (cur == 2'b00) nxt = 2'b00;
      else              nxt = cur - 2'b01;
    end else begin
      if (cur == 2'b11) nxt = 2'b11;
      else              nxt = cur + 2'b01;
    end
    return nxt;
  endfunction

  assign ghr_shift_s      = {ghr_r, ALU_stage_branch_result};
  assign unused_pc_bits_s = ^{ID_pc[31:IDX_BITS+2], ID_pc[1:0]};
  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

  // Table index: word-aligned PC bits, hashed with the global history in gshare mode.
  always_comb begin
    ghr_ext_s = '0;
    ghr_ext_s[HIST_BITS-1:0] = ghr_r;
    pc_index_s = ID_pc[IDX_BITS+1:2];
    if (MODE == 32'd2) ID_pred_index = pc_index_s ^ ghr_ext_s;
    else               ID_pred_index = pc_index_s;
  end

  // Direction prediction; reads the table as it stands this cycle (no bypass of ALU updates).
  always_comb begin
    if (reset || (MODE == 32'd0)) signal_to_take_branch = 1'b0;
    else signal_to_take_branch = ID_stage_branch & ~table_r[ID_pred_index][1];
  end

  // Misprediction is judged against the prediction carried down the pipe, not the table.
  always_comb begin
    mispredict_s = ALU_stage_branch & (ALU_predicted_taken ^ ALU_stage_branch_result);
    if (reset) begin
      flush       = 1'b0;
      redirect_pc = 32'h0000_0000;
    end else if (mispredict_s) begin
      flush       = 1'b1;
      redirect_pc = ALU_predicted_taken ? ALU_pc_plus4 : ALU_branch_target;
    end else begin
      flush       = 1'b0;
      redirect_pc = 32'h0000_0000;
    end
  end

  // Table, history and counter state; reset wins over a same-cycle resolution.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) table_r[i] <= INIT_STATE;
      ghr_r              <= '0;
      branch_count_r     <= '0;
      mispredict_count_r <= '0;
    end else if (ALU_stage_branch) begin
      if (MODE != 32'd0)
        table_r[ALU_pred_index] <= counter_next(table_r[ALU_pred_index], ALU_stage_branch_result);
      if (MODE == 32'd2)
        ghr_r <= ghr_shift_s[HIST_BITS-1:0];
      if (branch_count_r != '1)
        branch_count_r <= branch_count_r + CNT_BITS'(1'b1);
      if (flush && (mispredict_count_r != '1))
        mispredict_count_r <= mispredict_count_r + CNT_BITS'(1'b1);
    end
  end
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Scoreboard bench: bimodal, gshare, 2-bit-counter and static predictors share one stimulus stream.
module tb_branch_predictor_unit;
  localparam int SEL_TAKE = 0, SEL_IDX = 1, SEL_FLUSH = 2, SEL_REDIR = 3, SEL_BC = 4, SEL_MC = 5;
  localparam int SEL_G_IDX = 6, SEL_G_TAKE = 7, SEL_S_BC = 8, SEL_S_MC = 9, SEL_Z_TAKE = 10, SEL_Z_IDX = 11;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_pc;
  logic        id_branch, alu_branch, alu_result, alu_pred;
  logic [2:0]  alu_idx;
  logic [31:0] alu_plus4, alu_target;

  logic        b_take, b_flush, g_take, g_flush, s_take, s_flush, z_take, z_flush;
  logic [2:0]  b_idx, g_idx, s_idx, z_idx;
  logic [31:0] b_redir, g_redir, s_redir, z_redir;
  logic [15:0] b_bc, b_mc, g_bc, g_mc, z_bc, z_mc;
  logic [1:0]  s_bc, s_mc;

  always #5 clk = ~clk;

  branch_predictor_unit #(.MODE(1)) u_bim (
    .clk(clk), .reset(reset), .ID_pc(id_pc), .ID_stage_branch(id_branch),
    .signal_to_take_branch(b_take), .ID_pred_index(b_idx),
    .ALU_stage_branch(alu_branch), .ALU_stage_branch_result(alu_result),
    .ALU_predicted_taken(alu_pred), .ALU_pred_index(alu_idx),
    .ALU_pc_plus4(alu_plus4), .ALU_branch_target(alu_target),
    .flush(b_flush), .redirect_pc(b_redir), .branch_count(b_bc), .mispredict_count(b_mc));

  branch_predictor_unit #(.MODE(2), .HIST_BITS(3)) u_gsh (
    .clk(clk), .reset(reset), .ID_pc(id_pc), .ID_stage_branch(id_branch),
    .signal_to_take_branch(g_take), .ID_pred_index(g_idx),
    .ALU_stage_branch(alu_branch), .ALU_stage_branch_result(alu_result),
    .ALU_predicted_taken(alu_pred), .ALU_pred_index(alu_idx),
    .ALU_pc_plus4(alu_plus4), .ALU_branch_target(alu_target),
    .flush(g_flush), .redirect_pc(g_redir), .branch_count(g_bc), .mispredict_count(g_mc));

  branch_predictor_unit #(.MODE(1), .CNT_BITS(2)) u_sat (
    .clk(clk), .reset(reset), .ID_pc(id_pc), .ID_stage_branch(id_branch),
    .signal_to_take_branch(s_take), .ID_pred_index(s_idx),
    .ALU_stage_branch(alu_branch), .ALU_stage_branch_result(alu_result),
    .ALU_predicted_taken(alu_pred), .ALU_pred_index(alu_idx),
    .ALU_pc_plus4(alu_plus4), .ALU_branch_target(alu_target),
    .flush(s_flush), .redirect_pc(s_redir), .branch_count(s_bc), .mispredict_count(s_mc));

  branch_predictor_unit #(.MODE(0)) u_stat (
    .clk(clk), .reset(reset), .ID_pc(id_pc), .ID_stage_branch(id_branch),
    .signal_to_take_branch(z_take), .ID_pred_index(z_idx),
    .ALU_stage_branch(alu_branch), .ALU_stage_branch_result(alu_result),
    .ALU_predicted_taken(alu_pred), .ALU_pred_index(alu_idx),
    .ALU_pc_plus4(alu_plus4), .ALU_branch_target(alu_target),
    .flush(z_flush), .redirect_pc(z_redir), .branch_count(z_bc), .mispredict_count(z_mc));

  function automatic logic [31:0] observe(input int sel);
    logic [31:0] v;
    v = 32'h0;
    case (sel)
      SEL_TAKE:   v = {31'h0, b_take};
      SEL_IDX:    v = {29'h0, b_idx};
      SEL_FLUSH:  v = {31'h0, b_flush};
      SEL_REDIR:  v = b_redir;
      SEL_BC:     v = {16'h0, b_bc};
      SEL_MC:     v = {16'h0, b_mc};
      SEL_G_IDX:  v = {29'h0, g_idx};
      SEL_G_TAKE: v = {31'h0, g_take};
      SEL_S_BC:   v = {30'h0, s_bc};
      SEL_S_MC:   v = {30'h0, s_mc};
      SEL_Z_TAKE: v = {31'h0, z_take};
      SEL_Z_IDX:  v = {29'h0, z_idx};
      default:    v = 32'hdead_beef;
    endcase
    return v;
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] pc, input logic idb, input logic ab,
                       input logic res, input logic pred, input logic [2:0] aidx);
    id_pc      = pc;
    id_branch  = idb;
    alu_branch = ab;
    alu_result = res;
    alu_pred   = pred;
    alu_idx    = aidx;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Reset cycle carries a mispredicting resolution; the next cycle must show pristine state.
  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        reset = 1'b1;
        drive(32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4);
        push("rst_take", SEL_TAKE, 32'd0);
        push("rst_flush", SEL_FLUSH, 32'd0);
        push("rst_redir", SEL_REDIR, 32'd0);
      end else begin
        reset = 1'b0;
        drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        push("post_rst_take", SEL_TAKE, 32'd1);
        push("post_rst_idx", SEL_IDX, 32'd4);
        push("post_rst_flush", SEL_FLUSH, 32'd0);
        push("post_rst_bc", SEL_BC, 32'd0);
        push("post_rst_mc", SEL_MC, 32'd0);
        push("post_rst_gidx", SEL_G_IDX, 32'd4);
        push("static_take", SEL_Z_TAKE, 32'd0);
        push("static_idx", SEL_Z_IDX, 32'd4);
      end
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (observe(e.sel) !== e.exp) begin
          errors++;
          $display("FAIL %s: observed %0h expected %0h", e.tag, observe(e.sel), e.exp);
        end
      end
    end
  endtask

  // Entry 4 trained 01 -> 10 -> 11 by two mispredicted not-taken resolutions.
  task automatic test_not_taken_train();
    exp_t e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < 2) begin
        drive(32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4);
        push("nt_take", SEL_TAKE, (c == 0) ? 32'd1 : 32'd0);
        push("nt_flush", SEL_FLUSH, 32'd1);
        push("nt_redir", SEL_REDIR, 32'h14);
      end else begin
        drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        push("nt_take_after", SEL_TAKE, 32'd0);
        push("nt_flush_idle", SEL_FLUSH, 32'd0);
        push("nt_redir_idle", SEL_REDIR, 32'd0);
      end
      push("nt_bc", SEL_BC, c);
      push("nt_mc", SEL_MC, c);
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (observe(e.sel) !== e.exp) begin
          errors++;
          $display("FAIL %s(c%0d): observed %0h expected %0h", e.tag, c, observe(e.sel), e.exp);
        end
      end
    end
  endtask

  // Continues from entry 4 = 11: taken mispredictions redirect to target; ID reads pre-update value.
  task automatic test_taken_redirect();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (c < 2) begin
        drive(32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4);
        push("tk_take_old", SEL_TAKE, 32'd0);
        push("tk_flush", SEL_FLUSH, 32'd1);
        push("tk_redir", SEL_REDIR, 32'h40);
      end else begin
        drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        push("tk_take_new", SEL_TAKE, 32'd1);
        push("tk_flush_idle", SEL_FLUSH, 32'd0);
        push("tk_sat_bc", SEL_S_BC, 32'd3);
        push("tk_sat_mc", SEL_S_MC, 32'd3);
      end
      push("tk_bc", SEL_BC, 32'd2 + c);
      push("tk_mc", SEL_MC, 32'd2 + c);
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (observe(e.sel) !== e.exp) begin
          errors++;
          $display("FAIL %s(c%0d): observed %0h expected %0h", e.tag, c, observe(e.sel), e.exp);
        end
      end
    end
  endtask

  // Five mispredictions: 2-bit counters stop at 3, 16-bit counters keep counting.
  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < 5) drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
      else       drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      push("sat_mc", SEL_S_MC, (c < 3) ? c : 32'd3);
      push("sat_bc", SEL_S_BC, (c < 3) ? c : 32'd3);
      if (c == 5) begin
        push("wide_bc", SEL_BC, 32'd5);
        push("wide_mc", SEL_MC, 32'd5);
      end
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (observe(e.sel) !== e.exp) begin
          errors++;
          $display("FAIL %s(c%0d): observed %0h expected %0h", e.tag, c, observe(e.sel), e.exp);
        end
      end
    end
  endtask

  // History taken, taken, not-taken: index for PC 0x10 walks 4, 5, 7, then 4^6 = 2.
  task automatic test_gshare();
    exp_t e;
    logic [31:0] gexp [4];
    gexp[0] = 32'd4; gexp[1] = 32'd5; gexp[2] = 32'd7; gexp[3] = 32'd2;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      case (c)
        0, 1:    drive(32'h10, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        2:       drive(32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        default: drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      endcase
      push("gs_idx", SEL_G_IDX, gexp[c]);
      push("gs_bim_idx", SEL_IDX, 32'd4);
      push("gs_flush", SEL_FLUSH, 32'd0);
      if (c == 3) push("gs_take", SEL_G_TAKE, 32'd1);
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (observe(e.sel) !== e.exp) begin
          errors++;
          $display("FAIL %s(c%0d): observed %0h expected %0h", e.tag, c, observe(e.sel), e.exp);
        end
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    alu_plus4  = 32'h14;
    alu_target = 32'h40;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    test_reset();
    test_not_taken_train();
    test_taken_redirect();
    test_saturation();
    test_gshare();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
